// File: rtl/cic_interp.sv
// Order-3 CIC interpolator: combs at the input rate, zero-stuffed integrators at the
// output-tick rate, gain normalised to 1 for R = 2^k, k in 0..3.
module cic_interp #(
  parameter int ORDER             = 3,
  parameter int MAX_INT_RATE      = 8,
  parameter int INPUT_WIDTH       = 8,
  parameter int INPUT_FRAC_WIDTH  = 7,
  parameter int OUTPUT_WIDTH      = 8,
  parameter int OUTPUT_FRAC_WIDTH = 7
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    clear,
  input  logic                    enable,
  input  logic [INPUT_WIDTH-1:0]  data_in,
  input  logic                    data_in_ready,
  output logic                    data_req,
  input  logic                    out_tick,
  input  logic [1:0]              filter_int_factor,
  output logic                    data_out_ready,
  output logic [OUTPUT_WIDTH-1:0] data_out,
  output logic                    underflow,
  output logic                    overflow
);

  localparam int KMAX       = $clog2(MAX_INT_RATE);
  localparam int FULL_WIDTH = INPUT_WIDTH + ORDER * KMAX;
  localparam int TRUNC_LSB  = (ORDER - 1) * KMAX + INPUT_FRAC_WIDTH - OUTPUT_FRAC_WIDTH;
  localparam logic [OUTPUT_WIDTH-1:0] MAX_POS = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};

  logic [INPUT_WIDTH-1:0]        buf_data;
  logic                          buf_valid;
  logic [KMAX-1:0]               phase;
  logic [1:0]                    k_lat;
  logic signed [FULL_WIDTH-1:0]  d1, d2, d3, i1, i2, i3;

  logic                          tick, strobe, phase0, phase_wrap, rbit;
  logic [1:0]                    k_eff;
  logic [3:0]                    shamt;
  logic [INPUT_WIDTH-1:0]        x_sel;
  logic signed [FULL_WIDTH-1:0]  x_ext, s, c1, c2, c3;
  logic [OUTPUT_WIDTH-1:0]       trunc, rounded;
  logic                          unused_i3;

  assign data_req  = enable & ~buf_valid;
  assign unused_i3 = ^i3;

  always_comb begin
    tick   = enable & out_tick;
    strobe = enable & data_in_ready;
    phase0 = tick && (phase == '0);
    // the rate taken on a phase-0 tick governs both the scale and the period it starts
    k_eff      = phase0 ? filter_int_factor : k_lat;
    phase_wrap = int'(phase) >= ((1 << k_eff) - 1);
    shamt      = 4'((ORDER - 1) * (KMAX - int'(k_eff)));
    x_sel      = buf_valid ? buf_data : '0;
    x_ext      = {{(FULL_WIDTH-INPUT_WIDTH){x_sel[INPUT_WIDTH-1]}}, x_sel};
    s          = x_ext <<< shamt;
    c1         = s - d1;
    c2         = c1 - d2;
    c3         = c2 - d3;
    trunc      = i3[TRUNC_LSB +: OUTPUT_WIDTH];
    rbit       = i3[TRUNC_LSB-1];
    rounded    = (trunc == MAX_POS && rbit) ? MAX_POS : trunc + OUTPUT_WIDTH'(rbit);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      buf_data       <= '0;
      buf_valid      <= 1'b0;
      phase          <= '0;
      k_lat          <= '0;
      d1             <= '0;
      d2             <= '0;
      d3             <= '0;
      i1             <= '0;
      i2             <= '0;
      i3             <= '0;
      data_out       <= '0;
      data_out_ready <= 1'b0;
      underflow      <= 1'b0;
      overflow       <= 1'b0;
    end else if (clear) begin
      buf_data       <= '0;
      buf_valid      <= 1'b0;
      phase          <= '0;
      k_lat          <= '0;
      d1             <= '0;
      d2             <= '0;
      d3             <= '0;
      i1             <= '0;
      i2             <= '0;
      i3             <= '0;
      data_out       <= '0;
      data_out_ready <= 1'b0;
      underflow      <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      data_out_ready <= tick;
      underflow      <= phase0 & ~buf_valid;
      overflow       <= strobe & buf_valid & ~phase0;
      // a strobe landing on a consuming tick refills the buffer the tick just emptied
      if (strobe) begin
        buf_data  <= data_in;
        buf_valid <= 1'b1;
      end else if (phase0) begin
        buf_valid <= 1'b0;
      end
      if (tick) begin
        phase    <= phase_wrap ? '0 : phase + 1'b1;
        i2       <= i2 + i1;
        i3       <= i3 + i2;
        data_out <= rounded;
        if (phase0) begin
          k_lat <= filter_int_factor;
          d1    <= s;
          d2    <= c1;
          d3    <= c2;
          i1    <= i1 + c3;
        end
      end
    end
  end

endmodule

// File: tb/tb_cic_interp.sv
// Directed bench for cic_interp: identity vectors at k=0, DC settling at k=1..3,
// underflow/overflow pulses, simultaneous strobe+consume and mid-run clear.
module tb_cic_interp;

  logic       clk = 1'b0;
  logic       resetn, clear, enable;
  logic [7:0] data_in;
  logic       data_in_ready, data_req, out_tick;
  logic [1:0] filter_int_factor;
  logic       data_out_ready, underflow, overflow;
  logic [7:0] data_out;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0] din;
    logic [7:0] dout;
  } vec_t;
  vec_t id_tab[7];

  always #5 clk = ~clk;

  cic_interp dut (
    .clk               (clk),
    .resetn            (resetn),
    .clear             (clear),
    .enable            (enable),
    .data_in           (data_in),
    .data_in_ready     (data_in_ready),
    .data_req          (data_req),
    .out_tick          (out_tick),
    .filter_int_factor (filter_int_factor),
    .data_out_ready    (data_out_ready),
    .data_out          (data_out),
    .underflow         (underflow),
    .overflow          (overflow)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // one clock with the given tick/strobe; outputs are sampled 1 ns after the edge
  task automatic cyc(input logic t, input logic s, input logic [7:0] d);
    out_tick      = t;
    data_in_ready = s;
    data_in       = d;
    @(posedge clk);
    #1;
    out_tick      = 1'b0;
    data_in_ready = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc(1'b0, 1'b0, 8'h00);
    clear = 1'b0;
  endtask

  task automatic run_id(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b1, id_tab[i].din);
      cyc(1'b1, 1'b0, 8'h00);
      chk("id_out", int'(data_out), int'(id_tab[i].dout));
      chk("id_ready", int'(data_out_ready), 1);
      chk("id_no_underflow", int'(underflow), 0);
    end
  endtask

  task automatic dc_run(input logic [1:0] k, input int nticks);
    int uf = 0;
    do_clear();
    filter_int_factor = k;
    cyc(1'b0, 1'b1, 8'h20);
    for (int t = 1; t <= nticks; t++) begin
      cyc(1'b1, 1'b0, 8'h00);
      uf += int'(underflow);
      if (t >= 28) chk($sformatf("dc_k%0d_t%0d", k, t), int'(data_out), 'h20);
      if (data_req && t < nticks) cyc(1'b0, 1'b1, 8'h20);
    end
    chk($sformatf("dc_k%0d_no_underflow", k), uf, 0);
  endtask

  initial begin
    int uf;
    id_tab[0] = '{8'h10, 8'h00};
    id_tab[1] = '{8'h40, 8'h00};
    id_tab[2] = '{8'hC0, 8'h00};
    id_tab[3] = '{8'h7F, 8'h10};
    id_tab[4] = '{8'h00, 8'h40};
    id_tab[5] = '{8'h00, 8'hC0};
    id_tab[6] = '{8'h00, 8'h7F};

    resetn = 1'b0; clear = 1'b0; enable = 1'b0;
    data_in = 8'h00; data_in_ready = 1'b0; out_tick = 1'b0; filter_int_factor = 2'd0;

    // reset held with random activity on the inputs
    for (int i = 0; i < 6; i++) begin
      enable            = 1'($urandom_range(0, 1));
      out_tick          = 1'($urandom_range(0, 1));
      data_in_ready     = 1'($urandom_range(0, 1));
      data_in           = 8'($urandom);
      filter_int_factor = 2'($urandom);
      clear             = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    chk("rst_hold_out", int'(data_out), 0);
    chk("rst_hold_ready", int'(data_out_ready), 0);
    enable = 1'b0; out_tick = 1'b0; data_in_ready = 1'b0; clear = 1'b0;
    filter_int_factor = 2'd0;
    #1;
    chk("rst_req_disabled", int'(data_req), 0);
    enable = 1'b1;
    #2;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_out", int'(data_out), 0);
    chk("rst_ready", int'(data_out_ready), 0);
    chk("rst_underflow", int'(underflow), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_req", int'(data_req), 1);

    // enable low: tick and strobe are lost, no pulses
    enable = 1'b0;
    cyc(1'b1, 1'b1, 8'h55);
    chk("dis_ready", int'(data_out_ready), 0);
    chk("dis_underflow", int'(underflow), 0);
    chk("dis_overflow", int'(overflow), 0);
    enable = 1'b1;
    #1;
    chk("dis_req", int'(data_req), 1);

    // k=0 identity
    filter_int_factor = 2'd0;
    run_id(7);

    // mid-run clear with i3 non-zero and a pending sample, then a fresh run
    do_clear();
    run_id(3);
    cyc(1'b0, 1'b1, 8'h55);
    chk("clr_pending_req", int'(data_req), 0);
    do_clear();
    chk("clr_out", int'(data_out), 0);
    chk("clr_ready", int'(data_out_ready), 0);
    chk("clr_req", int'(data_req), 1);
    run_id(7);

    // DC gain at k=1, 3, then k=2 continued into the underflow scenario
    dc_run(2'd1, 40);
    dc_run(2'd3, 48);
    dc_run(2'd2, 41);
    uf = 0;
    for (int t = 0; t < 8; t++) begin
      cyc(1'b1, 1'b0, 8'h00);
      uf += int'(underflow);
    end
    chk("uf_count", uf, 2);
    for (int t = 0; t < 20; t++) cyc(1'b1, 1'b0, 8'h00);
    chk("uf_decay", int'(data_out), 0);

    // two strobes with no consuming tick: one overflow, second value kept
    do_clear();
    filter_int_factor = 2'd0;
    cyc(1'b0, 1'b1, 8'h11);
    chk("ov_first", int'(overflow), 0);
    cyc(1'b0, 1'b1, 8'h22);
    chk("ov_second", int'(overflow), 1);
    cyc(1'b0, 1'b0, 8'h00);
    chk("ov_once", int'(overflow), 0);
    cyc(1'b1, 1'b0, 8'h00);
    chk("ov_consume_req", int'(data_req), 1);
    chk("ov_consume_uf", int'(underflow), 0);
    cyc(1'b1, 1'b0, 8'h00);
    chk("ov_next_uf", int'(underflow), 1);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    chk("ov_value", int'(data_out), 'h22);

    // strobe coinciding with a phase-0 tick
    do_clear();
    cyc(1'b0, 1'b1, 8'h33);
    cyc(1'b1, 1'b1, 8'h44);
    chk("sim_overflow", int'(overflow), 0);
    chk("sim_underflow", int'(underflow), 0);
    chk("sim_req", int'(data_req), 0);
    cyc(1'b1, 1'b0, 8'h00);
    chk("sim_consume_uf", int'(underflow), 0);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    chk("sim_out_old", int'(data_out), 'h33);
    cyc(1'b1, 1'b0, 8'h00);
    chk("sim_out_new", int'(data_out), 'h44);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
